// File: rtl/core_uarch_pkg.sv
// Shared core micro-architecture types: register/word types, coprocessor
// decode fields and the coprocessor-control FSM state encoding.
package core_uarch_pkg;

  typedef logic [31:0] word;
  typedef logic [3:0]  reg_num;

  localparam reg_num R15 = 4'd15;

  // Fields produced by the coprocessor decoder; load=1 is MRC (coproc -> core)
  typedef struct packed {
    logic [3:0] crn;
    logic [3:0] crm;
    logic [2:0] op1;
    logic [2:0] op2;
    logic       load;
  } coproc_decode;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_COMPLETE = 2'd2,
    ST_FAULT    = 2'd3
  } coproc_ctrl_state;

endpackage

// File: rtl/core_coproc_timeout.sv
// REQ-phase watchdog: counts un-acked request cycles and flags the last
// allowed one.
module core_coproc_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (enable && !expired)
      cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/core_coproc_ctrl.sv
// Core-side coprocessor transfer controller (MCR/MRC): issues a request on the
// coprocessor bus, waits for ack/undef/timeout and retires the result.
module core_coproc_ctrl
  import core_uarch_pkg::*;
#(
  parameter int          TIMEOUT = 15,
  parameter logic [15:0] CP_MASK = 16'h8000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  coproc_decode decode,
  input  logic [3:0]   cp_sel,
  input  reg_num       rd_in,
  input  word          wdata,
  output logic         busy,
  output logic         done,
  output logic         undefined,
  output logic         writeback,
  output reg_num       rd,
  output word          result,
  output logic         update_flags,
  output logic [3:0]   flags,
  output logic         cp_req,
  output logic         cp_write,
  output logic [3:0]   cp_num,
  output logic [3:0]   cp_crn,
  output logic [3:0]   cp_crm,
  output logic [2:0]   cp_op1,
  output logic [2:0]   cp_op2,
  output word          cp_wdata,
  input  logic         cp_ack,
  input  logic         cp_undef,
  input  word          cp_rdata
);

  coproc_ctrl_state state, state_nxt;
  coproc_decode     dec_q;
  logic [3:0]       sel_q;
  reg_num           rd_q;
  word              wdata_q;
  word              rdata_q;
  logic             expired;

  core_coproc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_REQ),
    .enable  ((state == ST_REQ) && !cp_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Transfer operands are captured once at issue and held until the next issue
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q   <= '0;
      sel_q   <= '0;
      rd_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == ST_IDLE && start && !flush) begin
        dec_q   <= decode;
        sel_q   <= cp_sel;
        rd_q    <= rd_in;
        wdata_q <= wdata;
      end
      if (state == ST_REQ && cp_ack && !cp_undef && !flush)
        rdata_q <= cp_rdata;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != ST_IDLE);
    cp_req       = 1'b0;
    done         = 1'b0;
    undefined    = 1'b0;
    writeback    = 1'b0;
    update_flags = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = CP_MASK[cp_sel] ? ST_REQ : ST_FAULT;
      end
      ST_REQ: begin
        cp_req = 1'b1;
        // An ack on the last allowed cycle beats the watchdog
        if (cp_ack)
          state_nxt = cp_undef ? ST_FAULT : ST_COMPLETE;
        else if (expired)
          state_nxt = ST_FAULT;
      end
      ST_COMPLETE: begin
        done         = 1'b1;
        writeback    = dec_q.load && (rd_q != R15);
        update_flags = dec_q.load && (rd_q == R15);
        state_nxt    = ST_IDLE;
      end
      ST_FAULT: begin
        done      = 1'b1;
        undefined = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush)
      state_nxt = ST_IDLE;
  end

  assign cp_write = cp_req && !dec_q.load;
  assign cp_num   = sel_q;
  assign cp_crn   = dec_q.crn;
  assign cp_crm   = dec_q.crm;
  assign cp_op1   = dec_q.op1;
  assign cp_op2   = dec_q.op2;
  assign cp_wdata = wdata_q;
  assign rd       = rd_q;
  assign result   = rdata_q;
  assign flags    = rdata_q[31:28];

endmodule

// File: tb/tb_core_coproc_ctrl.sv
// Randomized transaction-level bench for core_coproc_ctrl with directed
// scenarios for latency, flags, timeout, undef, flush and reset behaviour.
module tb_core_coproc_ctrl;
  import core_uarch_pkg::*;

  localparam int          TIMEOUT = 15;
  localparam logic [15:0] CP_MASK = 16'h8000;
  localparam int P_REQ = 0, P_OK = 1, P_FLT = 2;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  coproc_decode decode;
  logic [3:0]   cp_sel;
  reg_num       rd_in;
  word          wdata;
  logic         busy, done, undefined, writeback, update_flags;
  reg_num       rd;
  word          result;
  logic [3:0]   flags;
  logic         cp_req, cp_write;
  logic [3:0]   cp_num, cp_crn, cp_crm;
  logic [2:0]   cp_op1, cp_op2;
  word          cp_wdata;
  logic         cp_ack, cp_undef;
  word          cp_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  core_coproc_ctrl #(.TIMEOUT(TIMEOUT), .CP_MASK(CP_MASK)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .decode(decode),
    .cp_sel(cp_sel), .rd_in(rd_in), .wdata(wdata), .busy(busy), .done(done),
    .undefined(undefined), .writeback(writeback), .rd(rd), .result(result),
    .update_flags(update_flags), .flags(flags), .cp_req(cp_req),
    .cp_write(cp_write), .cp_num(cp_num), .cp_crn(cp_crn), .cp_crm(cp_crm),
    .cp_op1(cp_op1), .cp_op2(cp_op2), .cp_wdata(cp_wdata), .cp_ack(cp_ack),
    .cp_undef(cp_undef), .cp_rdata(cp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic coproc_decode rand_dec();
    logic [14:0] v;
    v = 15'($urandom);
    return coproc_decode'(v);
  endfunction

  task automatic scramble_core();
    decode = rand_dec();
    cp_sel = 4'($urandom);
    rd_in  = 4'($urandom);
    wdata  = $urandom;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {27'd0, busy, done, undefined, writeback, update_flags}, 32'd0);
    check({tag, "_req"}, {30'd0, cp_req, cp_write}, 32'd0);
    check({tag, "_fld"}, {14'd0, cp_num, cp_crn, cp_crm, cp_op1, cp_op2}, 32'd0);
    check({tag, "_wdat"}, cp_wdata, 32'd0);
    check({tag, "_rd"}, {28'd0, rd}, 32'd0);
    check({tag, "_res"}, result, 32'd0);
    check({tag, "_flags"}, {28'd0, flags}, 32'd0);
  endtask

  // Expected per-cycle behaviour is built from the transfer rules, then
  // the bench drives the bus responses and checks each cycle.
  task automatic run_txn(input logic [3:0] sel, input coproc_decode dec, input reg_num rdn,
                         input word wd, input int ack_at, input logic und,
                         input word rdat, input int flush_at);
    int seq[$];
    int last;
    bit acked;
    if (!CP_MASK[sel]) begin
      seq.push_back(P_FLT);
    end else begin
      acked = (ack_at >= 0) && (ack_at < TIMEOUT);
      last  = acked ? ack_at : TIMEOUT - 1;
      if (flush_at >= 0 && flush_at <= last) begin
        for (int i = 0; i <= flush_at; i++) seq.push_back(P_REQ);
      end else begin
        for (int i = 0; i <= last; i++) seq.push_back(P_REQ);
        seq.push_back((acked && !und) ? P_OK : P_FLT);
      end
    end

    @(negedge clk);
    check("pre_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; flush = 1'b0; cp_ack = 1'b0; cp_undef = 1'b0;
    decode = dec; cp_sel = sel; rd_in = rdn; wdata = wd;

    for (int k = 0; k < seq.size(); k++) begin
      @(negedge clk);
      check("busy", {31'd0, busy}, 32'd1);
      check("rd", {28'd0, rd}, {28'd0, rdn});
      case (seq[k])
        P_REQ: begin
          check("req", {30'd0, cp_req, cp_write}, {30'd0, 1'b1, ~dec.load});
          check("req_fld", {14'd0, cp_num, cp_crn, cp_crm, cp_op1, cp_op2},
                {14'd0, sel, dec.crn, dec.crm, dec.op1, dec.op2});
          check("req_wdata", cp_wdata, wd);
          check("req_outs", {28'd0, done, undefined, writeback, update_flags}, 32'd0);
        end
        P_OK: begin
          check("ok_req", {31'd0, cp_req}, 32'd0);
          check("ok_outs", {28'd0, done, undefined, writeback, update_flags},
                {28'd0, 1'b1, 1'b0, dec.load && (rdn != 4'd15), dec.load && (rdn == 4'd15)});
          if (dec.load) begin
            check("ok_result", result, rdat);
            check("ok_flags", {28'd0, flags}, {28'd0, rdat[31:28]});
          end
        end
        default: begin
          check("flt_req", {31'd0, cp_req}, 32'd0);
          check("flt_outs", {28'd0, done, undefined, writeback, update_flags}, 32'h0000_000C);
        end
      endcase
      // Junk on the core side must be ignored while busy
      start = 1'($urandom);
      scramble_core();
      flush = (seq[k] == P_REQ) && (k == flush_at);
      if (seq[k] == P_REQ && k == ack_at) begin
        cp_ack = 1'b1; cp_undef = und; cp_rdata = rdat;
      end else begin
        cp_ack = 1'b0; cp_undef = 1'($urandom); cp_rdata = $urandom;
      end
    end

    @(negedge clk);
    check("end_idle", {28'd0, busy, done, cp_req, undefined}, 32'd0);
    start = 1'b0; flush = 1'b0; cp_ack = 1'b0; cp_undef = 1'b0;
  endtask

  initial begin
    coproc_decode d;
    rst = 1'b1; start = 1'b1; flush = 1'b1; cp_ack = 1'b1; cp_undef = 1'b0;
    cp_rdata = 32'hFFFF_FFFF;
    decode = rand_dec(); cp_sel = 4'd15; rd_in = 4'd3; wdata = 32'h5555_AAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0; start = 1'b0; flush = 1'b0; cp_ack = 1'b0;

    // MRC to R3, same-cycle ack
    d = rand_dec(); d.load = 1'b1;
    run_txn(4'd15, d, 4'd3, $urandom, 0, 1'b0, 32'h1234_5678, -1);
    // MRC to R15 loads flags
    d = rand_dec(); d.load = 1'b1;
    run_txn(4'd15, d, 4'd15, $urandom, 2, 1'b0, 32'hA000_0000, -1);
    // MCR acked after 4 waiting cycles
    d = rand_dec(); d.load = 1'b0;
    run_txn(4'd15, d, 4'd7, 32'hDEAD_BEEF, 4, 1'b0, $urandom, -1);
    // absent coprocessor, then undef ack
    run_txn(4'd14, rand_dec(), 4'd2, $urandom, 0, 1'b0, $urandom, -1);
    run_txn(4'd15, rand_dec(), 4'd2, $urandom, 1, 1'b1, $urandom, -1);
    // timeout, and ack on the last allowed cycle
    run_txn(4'd15, rand_dec(), 4'd4, $urandom, -1, 1'b0, $urandom, -1);
    d = rand_dec(); d.load = 1'b1;
    run_txn(4'd15, d, 4'd5, $urandom, TIMEOUT - 1, 1'b0, 32'hCAFE_F00D, -1);
    // flush beats a coincident ack, and a coincident timeout
    run_txn(4'd15, rand_dec(), 4'd6, $urandom, 1, 1'b0, $urandom, 1);
    run_txn(4'd15, rand_dec(), 4'd6, $urandom, -1, 1'b0, $urandom, TIMEOUT - 1);

    // flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; cp_sel = 4'd15;
    @(negedge clk);
    check("flush_start", {30'd0, busy, cp_req}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // reset during REQ clears everything on the next cycle
    @(negedge clk);
    start = 1'b1; cp_sel = 4'd15; decode = rand_dec(); rd_in = 4'd9; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("rstreq_req", {31'd0, cp_req}, 32'd1);
    start = 1'b0; rst = 1'b1; flush = 1'b1; cp_ack = 1'b1;
    @(negedge clk);
    check_zero("rst_in_req");
    rst = 1'b0; flush = 1'b0; cp_ack = 1'b0;

    for (int t = 0; t < 200; t++) begin
      logic [3:0] sel;
      int r, ack_at, flush_at;
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'd15;
      r = $urandom_range(0, 9);
      if (r == 0)      ack_at = -1;
      else if (r == 1) ack_at = TIMEOUT - 1;
      else if (r == 2) ack_at = TIMEOUT;
      else             ack_at = $urandom_range(0, 6);
      flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TIMEOUT - 1) : -1;
      run_txn(sel, rand_dec(), 4'($urandom), $urandom, ack_at,
              ($urandom_range(0, 4) == 0), $urandom, flush_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
